seq_match_ctrl: RTL and testbench

Controller that feeds a serial bit-pattern detector from a word-wide source. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first onto a 1-bit stream. It matches that stream against a programmable pattern, with overlapping matches allowed across word boundaries, and counts the matches. It reports completion after the word flagged last, and sits between a word producer (register file or FIFO) and the serial sequence-detection datapath.

---
 rtl/seq_match_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seq_match_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: takes parallel words over a valid/ready handshake,
// serializes each one MSB-first, and matches the resulting bit stream against
// a programmable pattern. Overlapping matches are allowed, including matches
// that span word boundaries. A saturating counter keeps the number of matches,
// and a one-cycle done pulse follows the word flagged last.
module seq_match_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [PAT_W-1:0]  pat_cfg_i,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              bit_out_o,
    output logic              bit_valid_o,
    output logic              match_o,
    output logic [CNT_W-1:0]  match_cnt_o,
    output logic              busy_o,
    output logic              done_o
);

    // Counter widths. The bit counter only needs to reach WORD_W-1.
    // The fill counter saturates at PAT_W.
    localparam int BIT_CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(WORD_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [WORD_W-1:0]   sreg_q, sreg_d;
    logic                last_q, last_d;
    logic [PAT_W-1:0]    hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic                match_q, match_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                shift_bit;
    logic [PAT_W-1:0]    window;
    logic                hit;

    // Match window: the history plus the bit being driven this cycle. A hit
    // needs at least PAT_W bits of this run to have been streamed. Without
    // that check, the zeroed history could form a false match.
    always_comb begin
        shift_bit = sreg_q[WORD_W-1];
        window    = {hist_q[PAT_W-2:0], shift_bit};
        hit       = (state_q == SHIFT) && (fill_q >= FILL_HIT) && (window == pat_q);
    end

    // Next-state logic for the control FSM and the datapath registers.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        sreg_d    = sreg_q;
        last_d    = last_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        bit_cnt_d = bit_cnt_q;
        match_d   = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pat_d     = pat_cfg_i;
                    cnt_d     = '0;
                    hist_d    = '0;
                    fill_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = LOAD;
                end
            end

            LOAD: begin
                if (in_valid_i) begin
                    sreg_d    = in_data_i;
                    last_d    = in_last_i;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                sreg_d    = {sreg_q[WORD_W-2:0], 1'b0};
                hist_d    = window;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
                if (hit) begin
                    match_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = last_q ? DONE : LOAD;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins in every state, so a
    // partially sent word is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            sreg_q    <= '0;
            last_q    <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            bit_cnt_q <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            sreg_q    <= sreg_d;
            last_q    <= last_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            bit_cnt_q <= bit_cnt_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    // Most outputs are decoded directly from the state. bit_out is gated so
    // that it reads 0 whenever no bit is being streamed.
    always_comb begin
        in_ready_o  = (state_q == LOAD);
        bit_valid_o = (state_q == SHIFT);
        bit_out_o   = (state_q == SHIFT) && shift_bit;
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == DONE);
        match_o     = match_q;
        match_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed testbench for seq_match_ctrl. Two instances share the same
// stimulus. The second uses a 2-bit counter so that counter saturation
// shows up with short runs.
module tb_seq_match_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] pat_cfg;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;

    logic       in_ready, bit_out, bit_valid, match, busy, done;
    logic [7:0] match_cnt;

    logic       sat_in_ready, sat_bit_out, sat_bit_valid, sat_match, sat_busy, sat_done;
    logic [1:0] sat_match_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    seq_match_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .pat_cfg_i   (pat_cfg),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_ready_o  (in_ready),
        .bit_out_o   (bit_out),
        .bit_valid_o (bit_valid),
        .match_o     (match),
        .match_cnt_o (match_cnt),
        .busy_o      (busy),
        .done_o      (done)
    );

    seq_match_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut_sat (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .pat_cfg_i   (pat_cfg),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_ready_o  (sat_in_ready),
        .bit_out_o   (sat_bit_out),
        .bit_valid_o (sat_bit_valid),
        .match_o     (sat_match),
        .match_cnt_o (sat_match_cnt),
        .busy_o      (sat_busy),
        .done_o      (sat_done)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net: the directed sequence is a few hundred cycles at most.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Step one cycle. Inputs are driven and outputs sampled 1 unit after the
    // rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] p, input logic v,
                                 input logic [7:0] d, input logic l);
        start    = s;
        pat_cfg  = p;
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    // Starts a run from IDLE. The caller is then in the first LOAD cycle.
    task automatic startRun(input logic [3:0] pat);
        applyStimulus(1'b1, pat, 1'b0, 8'h00, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("start_in_ready", in_ready, 1);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_cnt_clear", match_cnt, 0);
        checkOutput("start_sat_cnt_clear", sat_match_cnt, 0);
        checkOutput("start_sat_ctrl", {sat_in_ready, sat_busy}, 2'b11);
    endtask

    // Presents one word from a LOAD cycle and follows its 8 bits.
    // mmask[i-1] is the expected match in cycle a+i, for i = 1..9.
    // When poke is set, start and a new pat_cfg are driven mid-word.
    task automatic streamWord(input logic [7:0] data, input logic last,
                              input logic [8:0] mmask, input logic poke);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (poke && i == 3) begin
                start   = 1'b1;
                pat_cfg = 4'b1111;
            end
            if (poke && i == 4) start = 1'b0;
            checkOutput($sformatf("bit%0d_valid", i), bit_valid, 1);
            checkOutput($sformatf("bit%0d_out", i), bit_out, data[8-i]);
            checkOutput($sformatf("bit%0d_match", i), match, mmask[i-1]);
            checkOutput($sformatf("bit%0d_sat_match", i), sat_match, mmask[i-1]);
            checkOutput($sformatf("bit%0d_sat_bit", i), {sat_bit_valid, sat_bit_out},
                        {1'b1, data[8-i]});
            checkOutput($sformatf("bit%0d_no_ready", i), in_ready, 0);
            tick();
        end
        checkOutput("post_word_match", match, mmask[8]);
        checkOutput("post_word_sat_match", sat_match, mmask[8]);
        checkOutput("post_word_bit_valid", bit_valid, 0);
        checkOutput("post_word_done", done, last);
        checkOutput("post_word_in_ready", in_ready, !last);
    endtask

    // Checks the DONE cycle, then the IDLE cycle after it.
    task automatic finishRun(input logic [7:0] cnt, input logic [1:0] sat_cnt);
        checkOutput("done_pulse", done, 1);
        checkOutput("done_busy", busy, 1);
        checkOutput("done_cnt", match_cnt, cnt);
        checkOutput("done_sat_cnt", sat_match_cnt, sat_cnt);
        checkOutput("done_sat_pulse", sat_done, 1);
        tick();
        checkOutput("idle_done_clear", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_in_ready", in_ready, 0);
        checkOutput("idle_cnt_hold", match_cnt, cnt);
    endtask

    initial begin
        // Hold reset for 3 cycles. All outputs must then be idle.
        rst = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_outs", {in_ready, bit_out, bit_valid, match, busy, done}, 0);
        checkOutput("reset_cnt", match_cnt, 0);
        checkOutput("reset_sat_cnt", sat_match_cnt, 0);

        // in_valid pulsed while IDLE is not accepted.
        applyStimulus(1'b0, 4'b0000, 1'b1, 8'hFF, 1'b1);
        repeat (2) begin
            tick();
            checkOutput("idle_valid_ready", in_ready, 0);
            checkOutput("idle_valid_bits", {bit_valid, bit_out}, 0);
            checkOutput("idle_valid_busy", busy, 0);
        end
        in_valid = 1'b0;
        tick();

        // Single word 1011_0110 with pattern 1011.
        // Matches appear at a+5 and a+8.
        // The pattern input changes after the latch and has no effect.
        startRun(4'b1011);
        pat_cfg = 4'b0000;
        streamWord(8'b1011_0110, 1'b1, 9'b0_1001_0000, 1'b0);
        finishRun(8'd2, 2'd2);

        // One match that spans a word boundary. A 4-cycle gap separates the words.
        startRun(4'b1011);
        streamWord(8'h01, 1'b0, 9'b0_0000_0000, 1'b0);
        repeat (3) begin
            tick();
            checkOutput("gap_in_ready", in_ready, 1);
            checkOutput("gap_bit_valid", bit_valid, 0);
            checkOutput("gap_busy", busy, 1);
        end
        streamWord(8'h60, 1'b1, 9'b0_0000_1000, 1'b0);
        finishRun(8'd1, 2'd1);

        // All-zero pattern and data. Nothing matches before the 4th bit.
        // There are 5 pulses, and the 2-bit counter stops at 3.
        startRun(4'b0000);
        streamWord(8'h00, 1'b1, 9'b1_1111_0000, 1'b0);
        finishRun(8'd5, 2'd3);

        // start and pat_cfg=1111 are driven during SHIFT and must be ignored.
        startRun(4'b1011);
        streamWord(8'b1011_0110, 1'b1, 9'b0_1001_0000, 1'b1);
        finishRun(8'd2, 2'd2);
        tick();
        checkOutput("no_restart_busy", busy, 0);
        checkOutput("no_restart_ready", in_ready, 0);

        // Reset asserted in the 3rd SHIFT cycle.
        startRun(4'b1011);
        applyStimulus(1'b0, 4'b1011, 1'b1, 8'hBB, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("pre_reset_shift", bit_valid, 1);
        rst = 1'b1;
        tick();
        checkOutput("midrst_outs", {in_ready, bit_out, bit_valid, match, busy, done}, 0);
        checkOutput("midrst_cnt", match_cnt, 0);
        checkOutput("midrst_sat_cnt", sat_match_cnt, 0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_outs", {in_ready, bit_out, bit_valid, match, busy, done}, 0);

        // A fresh run after the reset.
        // For 1011_1011, matches appear at a+5 and at a+9, which is the DONE cycle.
        startRun(4'b1011);
        streamWord(8'b1011_1011, 1'b1, 9'b1_0001_0000, 1'b0);
        finishRun(8'd2, 2'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
